// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receive path with a first-word-fall-through byte FIFO.
//
// The line is synchronized and sampled at the middle of each bit. A start bit
// that is no longer low at its mid-point is treated as a glitch and dropped.
// Each received byte is pushed into a FIFO that the CPU reads from.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   uart_rx    serial line, idle high, asynchronous to clk
//   rx_data    byte at the FIFO head; reads as 0 while the FIFO is empty
//   rx_valid   FIFO not empty
//   rx_ren     pop the head byte this cycle; ignored while rx_valid=0
//   rx_count   number of bytes currently held in the FIFO
//   busy       a frame is being received (FSM not idle)
//   frame_err  sticky: a stop bit was sampled low
//   overflow   sticky: a complete byte was dropped because the FIFO was full
//   err_clr    clears frame_err and overflow; a new error in the same cycle wins
module uart_receiver #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ren,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          err_clr
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int PTR_W        = AW + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Line synchronizer plus one history flop for falling-edge detection.
  // Reset to 1 so that reset release is never seen as a start edge.
  // ---------------------------------------------------------------------------
  logic sync_1, line_cur, line_prev;

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge value of its source, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1    <= 1'b1;
      line_cur  <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_1    <= uart_rx;
      line_cur  <= sync_1;
      line_prev <= line_cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_done;   // stop bit good: push shift_q
  logic             stop_bad;    // stop bit low: discard, flag framing error

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Only a high-to-low transition starts a frame, so a line held low
        // (break) cannot retrigger.
        if (line_prev && !line_cur) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!line_cur) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;     // glitch: start bit gone by mid-point
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d = {line_cur, shift_q[7:1]};   // LSB arrives first
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (line_cur) byte_done = 1'b1;
          else          stop_bad  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Receive FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, do_pop, do_push, drop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop     = rx_ren && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign do_push    = byte_done && (!fifo_full || do_pop);
  assign drop       = byte_done && fifo_full && !do_pop;

  assign rx_valid = !fifo_empty;
  assign rx_count = wr_ptr - rd_ptr;
  assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the storage array has no reset; empty slots are never visible
  // because rx_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shift_q;
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new event takes priority over err_clr.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (stop_bad)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (drop)         overflow  <= 1'b1;
      else if (err_clr) overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: 10 clocks per bit, 4-entry FIFO.
// Expected bytes go into a queue as frames are sent and are popped and
// compared as the DUT presents them at the FIFO head.
module tb_uart_receiver;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ren = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       busy, frame_err, overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];     // expected FIFO contents, head first
  logic       exp_ovf = 1'b0;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ  (1000000),
    .BAUD      (100000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ren   (rx_ren),
    .rx_count (rx_count),
    .busy     (busy),
    .frame_err(frame_err),
    .overflow (overflow),
    .err_clr  (err_clr)
  );

  // All stimulus changes happen 1 ns after a rising edge; outputs are read there too.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
  endtask

  // Sends a good frame and updates the FIFO model.
  task automatic send_byte(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                      exp_ovf = 1'b1;
    send_frame(b, 1'b1);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    tick(n);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] exp;
    int waited = 0;
    while (!rx_valid && waited < 200) begin
      tick(1);
      waited++;
    end
    vectors++;
    if (!rx_valid) begin
      miscompares++;
      $display("FAIL %s: rx_valid still 0 after %0d cycles, want 1", name, waited);
    end else if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got byte %02h, want none", name, rx_data);
    end else begin
      exp = exp_q.pop_front();
      if (rx_data !== exp) begin
        miscompares++;
        $display("FAIL %s: rx_data got %02h want %02h", name, rx_data, exp);
      end
      rx_ren = 1'b1;
      tick(1);
      rx_ren = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    vectors++;
    if ({rx_valid, rx_count, busy, frame_err, overflow, rx_data} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_in: got v=%b c=%0d b=%b fe=%b ov=%b d=%02h want all 0",
               rx_valid, rx_count, busy, frame_err, overflow, rx_data);
    end
    tick(3);
    reset = 1'b1;
    tick(5);
    vectors++;
    if ({rx_valid, rx_count, busy, frame_err, overflow} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_out: got v=%b c=%0d b=%b fe=%b ov=%b want all 0",
               rx_valid, rx_count, busy, frame_err, overflow);
    end
  endtask

  task automatic test_single_byte;
    int lat = 0;
    // Start edge driven after edge k: synchronizer 2, edge register 1,
    // half bit 5, 8 data bits 80, stop bit 10 -> push at edge k+98.
    fork
      send_byte(8'hA5);
      while (!rx_valid && lat < 200) begin
        tick(1);
        lat++;
      end
    join
    vectors++;
    if (lat != 98) begin
      miscompares++;
      $display("FAIL single_latency: rx_valid after %0d cycles want 98", lat);
    end
    vectors++;
    if (rx_count !== 3'd1) begin
      miscompares++;
      $display("FAIL single_count: got %0d want 1", rx_count);
    end
    pop_check("single_data");
    vectors++;
    if ({rx_valid, rx_count, frame_err, overflow} !== 6'd0) begin
      miscompares++;
      $display("FAIL single_after_pop: got v=%b c=%0d fe=%b ov=%b want all 0",
               rx_valid, rx_count, frame_err, overflow);
    end
  endtask

  task automatic test_glitch;
    int waited = 0;
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy: got %b want 1", busy);
    end
    while (busy && waited < 8) begin
      tick(1);
      waited++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_idle: busy still %b after 8 cycles, want 0", busy);
    end
    tick(5);
    vectors++;
    if ({rx_valid, frame_err, overflow} !== 3'd0) begin
      miscompares++;
      $display("FAIL glitch_noflag: got v=%b fe=%b ov=%b want 0", rx_valid, frame_err, overflow);
    end
    send_byte(8'h3C);
    pop_check("glitch_next_byte");
  endtask

  task automatic test_frame_break;
    int busy_hits = 0;
    send_frame(8'h55, 1'b0);    // line left low: break
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy) busy_hits++;
    end
    vectors++;
    if (busy_hits != 0) begin
      miscompares++;
      $display("FAIL break_restart: busy seen %0d cycles want 0", busy_hits);
    end
    vectors++;
    if ({frame_err, rx_count} !== {1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL frame_err_set: got fe=%b c=%0d want fe=1 c=0", frame_err, rx_count);
    end
    idle(20);
    send_byte(8'h81);
    pop_check("after_break_data");
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_err_sticky: got %b want 1", frame_err);
    end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_err_clr: got %b want 0", frame_err);
    end
  endtask

  task automatic test_overflow;
    for (int v = 1; v <= 5; v++) send_byte(8'(v));
    idle(2);
    vectors++;
    if ({rx_count, overflow} !== {3'(exp_q.size()), exp_ovf}) begin
      miscompares++;
      $display("FAIL overflow_state: got c=%0d ov=%b want c=%0d ov=%b",
               rx_count, overflow, exp_q.size(), exp_ovf);
    end
    for (int i = 0; i < DEPTH; i++) pop_check("overflow_drain");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    exp_ovf = 1'b0;
    vectors++;
    if ({rx_count, overflow} !== 4'd0) begin
      miscompares++;
      $display("FAIL overflow_clr: got c=%0d ov=%b want 0", rx_count, overflow);
    end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] head;
    for (int v = 8'h10; v <= 8'h13; v++) send_byte(8'(v));
    idle(2);
    vectors++;
    if (rx_count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_fill: got c=%0d want 4", rx_count);
    end
    // Model: head popped and 0x14 pushed on the same edge.
    head = exp_q.pop_front();
    exp_q.push_back(8'h14);
    fork
      send_frame(8'h14, 1'b1);
      begin
        repeat (97) @(posedge clk);
        #1;
        vectors++;
        if (rx_data !== head) begin
          miscompares++;
          $display("FAIL full_pop_head: got %02h want %02h", rx_data, head);
        end
        rx_ren = 1'b1;          // sampled on the push edge (k+98)
        tick(1);
        rx_ren = 1'b0;
      end
    join
    vectors++;
    if ({rx_count, overflow} !== {3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL full_push_pop: got c=%0d ov=%b want c=4 ov=0", rx_count, overflow);
    end
    for (int i = 0; i < DEPTH; i++) pop_check("full_drain");
    rx_ren = 1'b1;              // pop while empty: no effect
    tick(1);
    rx_ren = 1'b0;
    vectors++;
    if ({rx_valid, rx_count} !== 4'd0) begin
      miscompares++;
      $display("FAIL empty_pop: got v=%b c=%0d want 0", rx_valid, rx_count);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b = 8'hF0;
    send_byte(8'h21);
    send_byte(8'h22);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    vectors++;
    if ({busy, rx_count} !== {1'b1, 3'd2}) begin
      miscompares++;
      $display("FAIL midframe_pre: got b=%b c=%0d want b=1 c=2", busy, rx_count);
    end
    reset = 1'b0;
    #1;
    exp_q.delete();
    vectors++;
    if ({rx_valid, rx_count, busy, rx_data} !== 12'd0) begin
      miscompares++;
      $display("FAIL midframe_reset: got v=%b c=%0d b=%b d=%02h want 0",
               rx_valid, rx_count, busy, rx_data);
    end
    uart_rx = 1'b1;
    tick(1);
    reset = 1'b1;
    idle(20);
    send_byte(8'h7E);
    pop_check("post_reset_byte");
    vectors++;
    if (rx_count !== 3'd0) begin
      miscompares++;
      $display("FAIL post_reset_count: got %0d want 0", rx_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    idle(15);
    test_glitch();
    idle(15);
    test_frame_break();
    idle(15);
    test_overflow();
    idle(15);
    test_full_push_pop();
    idle(15);
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive path for the SoC: 8N1 serial deserializer with a first-word-fall-through byte FIFO toward the CPU bus.
- Complements the transmit side that drives uart_tx through wen/data_in.
- Sits between the uart_rx pad and the uart controller's register read port.
- Mid-bit sampling with start-bit glitch rejection; sticky framing and overflow flags.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be >= 4
FIFO_DEPTH, 16, receive FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
uart_rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  byte at FIFO head; valid only when rx_valid=1
rx_valid  output  1  FIFO not empty
rx_ren  input  1  pop head byte this cycle; ignored when rx_valid=0
rx_count  output  $clog2(FIFO_DEPTH)+1  bytes currently held
busy  output  1  FSM not in IDLE
frame_err  output  1  sticky: stop bit sampled low
overflow  output  1  sticky: complete byte dropped because FIFO full
err_clr  input  1  clears frame_err and overflow

Behaviour:
- Reset (reset=0, asynchronous): synchronizer flops=1, FSM=IDLE, counters=0, FIFO empty; rx_valid=0, rx_count=0, busy=0, frame_err=0, overflow=0, rx_data=0.
- Input synchronization: 2-flop synchronizer, reset value 1. A third flop holds the previous synchronized value for edge detection. Line-to-FSM latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP. cnt is the bit-period counter; idx counts 0..7.
- IDLE: on synchronized falling edge (prev=1, cur=0), go to START with cnt=0. A line held low does not retrigger.
- START: increment cnt. At cnt == CLKS_PER_BIT/2 - 1, sample the line.
  - Line 0: go to DATA with cnt=0, idx=0.
  - Line 1: glitch; return to IDLE with no flag.
- DATA: at cnt == CLKS_PER_BIT-1, sample. The shift register shifts right and the sample enters bit 7 (LSB first on the wire). Then idx++ and cnt=0. After the sample at idx=7, go to STOP.
- STOP: at cnt == CLKS_PER_BIT-1, sample, then return to IDLE.
  - Sample 1: push the byte.
  - Sample 0: discard the byte and set frame_err. A break (line stays low) causes no further starts until the line returns high.
- Push timing: the push occurs in the STOP-sample cycle. rx_valid rises the following cycle. Mid-point of stop bit to rx_valid is 1 cycle.
- FIFO storage: read/write pointers are $clog2(FIFO_DEPTH)+1 bits wide; the MSB distinguishes full from empty.
- FIFO outputs: rx_data is combinational from the head entry. rx_count = wr_ptr - rd_ptr.
- Pop: rx_ren with rx_valid=1 advances rd_ptr at the clock edge. rx_ren with rx_valid=0 has no effect.
- Push when full:
  - Without a simultaneous pop: the byte is dropped, overflow set, FIFO contents unchanged.
  - With a simultaneous valid pop: both occur and rx_count stays FIFO_DEPTH.
- Simultaneous push and pop when non-full: rx_count unchanged.
- Flags: frame_err and overflow are sticky. err_clr clears both; if a new error event occurs in the same cycle, set wins.
- busy = (state != IDLE).
- Reset mid-frame: immediate return to reset values. Partial byte and FIFO contents are lost.

Test Plan:
CLK_FREQ=1000000, BAUD=100000 (CLKS_PER_BIT=10), FIFO_DEPTH=4 unless noted.
1. Single byte: send 0xA5 8N1 -> rx_valid rises 1 cycle after stop mid-point; rx_data=0xA5, rx_count=1; rx_ren pulse -> rx_valid=0, rx_count=0; frame_err=overflow=0.
2. Glitch rejection: uart_rx low for 3 cycles then high -> FSM returns to IDLE, no push, no flags, busy deasserted within 8 cycles. Then send 0x3C -> 0x3C received.
3. Framing error and break: send 0x55 with stop bit 0, hold line low 40 cycles -> frame_err=1, rx_count=0, single start only. Then line high, send 0x81 -> rx_data=0x81, frame_err still 1. err_clr -> frame_err=0.
4. Overflow: send 0x01..0x05 back-to-back without reads -> rx_count=4, overflow=1; pops yield 0x01,0x02,0x03,0x04.
5. Push+pop when full: fill with 0x10..0x13, assert rx_ren in the cycle 0x14 is pushed -> overflow=0, rx_count=4; drain yields 0x11,0x12,0x13,0x14.
6. Reset mid-frame: assert reset after 4 data bits of 0xF0 with 2 bytes queued -> immediately rx_valid=0, rx_count=0, busy=0. After release, send 0x7E -> 0x7E received correctly.
